// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types for the EX-stage forwarding and load-use hazard unit.
// The FWD_HAZARD_PERF_EN build option is handled in fwd_hazard_unit.sv.
package fwd_hazard_unit_pkg;

  localparam int FWD_SEL_W = 3;

  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_RF      = 3'd0,
    FWD_MEM_ALU = 3'd1,
    FWD_MEM_BR  = 3'd2,
    FWD_WB      = 3'd3,
    FWD_HELD    = 3'd4
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } fwd_state_t;

endpackage

// File: rtl/fwd_hazard_unit_src_select.sv
// One source operand: priority forwarding select, load-use flag and the
// hold register that keeps a WB-forwarded value alive while EX is frozen.
module fwd_src_select
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  rs,
  input  logic              idex_valid,
  input  logic              ex_advance,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic              exmem_load_reg,
  input  logic              exmem_is_load,
  input  logic              exmem_is_cmp,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic              memwb_load_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              dmem_stall,
  output fwd_sel_t          sel,
  output logic              hazard,
  output logic [DATA_W-1:0] hold_data
);

  logic held_valid;
  logic mem_match;
  logic wb_match;

  always_comb begin
    mem_match = exmem_load_reg && (exmem_rd == rs) && (exmem_rd != '0);
    wb_match  = memwb_load_reg && (memwb_rd == rs) && (memwb_rd != '0);
    sel       = FWD_RF;
    hazard    = 1'b0;
    if (!rst || !idex_valid || (rs == '0)) begin
      sel = FWD_RF;
    end else if (mem_match) begin
      // A load in MEM has no data yet: flag it and let the stall cover it
      if (exmem_is_load) hazard = 1'b1;
      else               sel    = exmem_is_cmp ? FWD_MEM_BR : FWD_MEM_ALU;
    end else if (wb_match) begin
      sel = FWD_WB;
    end else if (held_valid) begin
      sel = FWD_HELD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_valid <= 1'b0;
      hold_data  <= '0;
    end else if (!dmem_stall) begin
      if (ex_advance) begin
        held_valid <= 1'b0;
      end else if (sel == FWD_WB) begin
        hold_data  <= wb_data;
        held_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding selector with load-use stall/bubble FSM.
// Define FWD_HAZARD_PERF_EN to add perf_lu_stalls / perf_fwd_events counters.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int REG_W   = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_W-1:0]  idex_rs,
  input  logic                      idex_valid,
  input  logic                      ex_advance,
  input  logic [REG_W-1:0]          exmem_rd,
  input  logic                      exmem_load_reg,
  input  logic                      exmem_is_load,
  input  logic                      exmem_is_cmp,
  input  logic [REG_W-1:0]          memwb_rd,
  input  logic                      memwb_load_reg,
  input  logic [DATA_W-1:0]         wb_data,
  input  logic                      dmem_stall,
  output logic [NUM_SRC*3-1:0]      fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0] fwd_held_data,
`ifdef FWD_HAZARD_PERF_EN
  output logic [31:0]               perf_lu_stalls,
  output logic [31:0]               perf_fwd_events,
`endif
  output logic                      stall_front,
  output logic                      bubble_ex
);

  fwd_sel_t     sel_arr [NUM_SRC];
  logic [NUM_SRC-1:0] hazard_vec;
  logic         lu_hazard;
  fwd_state_t   state;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_select #(.REG_W(REG_W), .DATA_W(DATA_W)) u_src (
      .clk            (clk),
      .rst            (rst),
      .rs             (idex_rs[i*REG_W +: REG_W]),
      .idex_valid     (idex_valid),
      .ex_advance     (ex_advance),
      .exmem_rd       (exmem_rd),
      .exmem_load_reg (exmem_load_reg),
      .exmem_is_load  (exmem_is_load),
      .exmem_is_cmp   (exmem_is_cmp),
      .memwb_rd       (memwb_rd),
      .memwb_load_reg (memwb_load_reg),
      .wb_data        (wb_data),
      .dmem_stall     (dmem_stall),
      .sel            (sel_arr[i]),
      .hazard         (hazard_vec[i]),
      .hold_data      (fwd_held_data[i*DATA_W +: DATA_W])
    );
    assign fwd_sel[i*3 +: 3] = sel_arr[i];
  end

  assign lu_hazard = |hazard_vec;

  // One bubble per load-use: the LU_STALL cycle sees the load in WB instead
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else if (!dmem_stall) begin
      case (state)
        RUN:      if (lu_hazard) state <= LU_STALL;
        LU_STALL: state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

  always_comb begin
    stall_front = rst && (state == RUN) && lu_hazard && !dmem_stall;
    bubble_ex   = stall_front;
  end

`ifdef FWD_HAZARD_PERF_EN
  logic any_fwd;

  always_comb begin
    any_fwd = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_arr[i] != FWD_RF) any_fwd = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_lu_stalls  <= '0;
      perf_fwd_events <= '0;
    end else begin
      if (!dmem_stall && (state == RUN) && lu_hazard) perf_lu_stalls <= perf_lu_stalls + 32'd1;
      if (idex_valid && ex_advance && any_fwd)        perf_fwd_events <= perf_fwd_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: a rule-level reference model checked every cycle
// plus directed vectors with hand-computed expectations.
module tb_fwd_hazard_unit;

  localparam int NUM_SRC = 2;
  localparam int REG_W   = 5;
  localparam int DATA_W  = 32;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [NUM_SRC*REG_W-1:0]  idex_rs = '0;
  logic                      idex_valid = 1'b0;
  logic                      ex_advance = 1'b0;
  logic [REG_W-1:0]          exmem_rd = '0;
  logic                      exmem_load_reg = 1'b0;
  logic                      exmem_is_load = 1'b0;
  logic                      exmem_is_cmp = 1'b0;
  logic [REG_W-1:0]          memwb_rd = '0;
  logic                      memwb_load_reg = 1'b0;
  logic [DATA_W-1:0]         wb_data = '0;
  logic                      dmem_stall = 1'b0;
  logic [NUM_SRC*3-1:0]      fwd_sel;
  logic [NUM_SRC*DATA_W-1:0] fwd_held_data;
  logic                      stall_front;
  logic                      bubble_ex;
`ifdef FWD_HAZARD_PERF_EN
  logic [31:0]               perf_lu_stalls;
  logic [31:0]               perf_fwd_events;
`endif

  int checks = 0;
  int errors = 0;

  fwd_hazard_unit #(.NUM_SRC(NUM_SRC), .REG_W(REG_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .idex_rs        (idex_rs),
    .idex_valid     (idex_valid),
    .ex_advance     (ex_advance),
    .exmem_rd       (exmem_rd),
    .exmem_load_reg (exmem_load_reg),
    .exmem_is_load  (exmem_is_load),
    .exmem_is_cmp   (exmem_is_cmp),
    .memwb_rd       (memwb_rd),
    .memwb_load_reg (memwb_load_reg),
    .wb_data        (wb_data),
    .dmem_stall     (dmem_stall),
    .fwd_sel        (fwd_sel),
    .fwd_held_data  (fwd_held_data),
`ifdef FWD_HAZARD_PERF_EN
    .perf_lu_stalls (perf_lu_stalls),
    .perf_fwd_events(perf_fwd_events),
`endif
    .stall_front    (stall_front),
    .bubble_ex      (bubble_ex)
  );

  always #5 clk = ~clk;

  // Reference model state: whether the previous cycle already issued the bubble,
  // and which sources still hold a value captured from WB
  bit                m_in_stall;
  bit                m_hv   [NUM_SRC];
  logic [DATA_W-1:0] m_hold [NUM_SRC];

  function automatic logic [REG_W-1:0] srcIdx(input int i);
    return idex_rs[i*REG_W +: REG_W];
  endfunction

  function automatic bit modelHazard(input int i);
    logic [REG_W-1:0] r;
    r = srcIdx(i);
    return rst && idex_valid && (r != 0) && exmem_load_reg && (exmem_rd == r) && exmem_is_load;
  endfunction

  function automatic logic [2:0] modelSel(input int i);
    logic [REG_W-1:0] r;
    r = srcIdx(i);
    if (!rst || !idex_valid || r == 0) return 3'd0;
    if (exmem_load_reg && exmem_rd == r) return exmem_is_load ? 3'd0 : (exmem_is_cmp ? 3'd2 : 3'd1);
    if (memwb_load_reg && memwb_rd == r) return 3'd3;
    if (m_hv[i]) return 3'd4;
    return 3'd0;
  endfunction

  function automatic bit modelStall();
    bit any_hz;
    any_hz = 0;
    for (int i = 0; i < NUM_SRC; i++) any_hz |= modelHazard(i);
    return rst && !m_in_stall && any_hz && !dmem_stall;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_in_stall = 0;
      for (int i = 0; i < NUM_SRC; i++) begin
        m_hv[i]   = 0;
        m_hold[i] = '0;
      end
    end else if (!dmem_stall) begin
      logic [2:0] s [NUM_SRC];
      bit st;
      for (int i = 0; i < NUM_SRC; i++) s[i] = modelSel(i);
      st = modelStall();
      for (int i = 0; i < NUM_SRC; i++) begin
        if (ex_advance) m_hv[i] = 0;
        else if (s[i] == 3'd3) begin
          m_hold[i] = wb_data;
          m_hv[i]   = 1;
        end
      end
      m_in_stall = st;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [NUM_SRC*3-1:0]      e_sel;
    logic [NUM_SRC*DATA_W-1:0] e_hold;
    for (int i = 0; i < NUM_SRC; i++) begin
      e_sel[i*3 +: 3]           = modelSel(i);
      e_hold[i*DATA_W +: DATA_W] = m_hold[i];
    end
    checkOutput("model_fwd_sel", 64'(fwd_sel), 64'(e_sel));
    checkOutput("model_held_data", 64'(fwd_held_data), 64'(e_hold));
    checkOutput("model_stall_front", 64'(stall_front), 64'(modelStall()));
    checkOutput("model_bubble_ex", 64'(bubble_ex), 64'(modelStall()));
  end

  task automatic applyStimulus(
    input logic [REG_W-1:0] rs0, input logic [REG_W-1:0] rs1,
    input logic valid, input logic adv,
    input logic [REG_W-1:0] exrd, input logic exld, input logic exisld, input logic excmp,
    input logic [REG_W-1:0] wbrd, input logic wbld, input logic [DATA_W-1:0] wbd,
    input logic dstall);
    @(posedge clk);
    #1;
    idex_rs        = {rs1, rs0};
    idex_valid     = valid;
    ex_advance     = adv;
    exmem_rd       = exrd;
    exmem_load_reg = exld;
    exmem_is_load  = exisld;
    exmem_is_cmp   = excmp;
    memwb_rd       = wbrd;
    memwb_load_reg = wbld;
    wb_data        = wbd;
    dmem_stall     = dstall;
  endtask

  task automatic checkCycle(input string name, input logic [2:0] s0, input logic [2:0] s1, input logic st);
    @(negedge clk);
    #1;
    checkOutput({name, "_sel"}, 64'(fwd_sel), 64'({s1, s0}));
    checkOutput({name, "_stall"}, 64'(stall_front), 64'(st));
    checkOutput({name, "_bubble"}, 64'(bubble_ex), 64'(st));
  endtask

  initial begin
    $display("[TB] start");
    checkCycle("reset", 3'd0, 3'd0, 1'b0);
    checkOutput("reset_held", 64'(fwd_held_data), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    applyStimulus(5, 5, 1, 1, 5, 1, 0, 0, 0, 0, 32'h0, 0);
    checkCycle("mem_alu", 3'd1, 3'd1, 1'b0);
    applyStimulus(7, 0, 1, 1, 7, 1, 0, 1, 0, 0, 32'h0, 0);
    checkCycle("slt_fwd", 3'd2, 3'd0, 1'b0);
    applyStimulus(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 32'h0, 0);
    checkCycle("rd_zero", 3'd0, 3'd0, 1'b0);
    applyStimulus(0, 3, 1, 1, 3, 1, 0, 0, 3, 1, 32'h1111, 0);
    checkCycle("prio_mem", 3'd0, 3'd1, 1'b0);
    applyStimulus(0, 3, 1, 1, 3, 0, 0, 0, 3, 1, 32'h1111, 0);
    checkCycle("prio_wb", 3'd0, 3'd3, 1'b0);
    applyStimulus(3, 3, 0, 1, 3, 1, 0, 0, 0, 0, 32'h0, 0);
    checkCycle("invalid_ex", 3'd0, 3'd0, 1'b0);

    applyStimulus(9, 9, 1, 0, 9, 1, 1, 0, 0, 0, 32'h0, 0);
    checkCycle("lu_hazard", 3'd0, 3'd0, 1'b1);
    applyStimulus(9, 9, 1, 1, 0, 0, 0, 0, 9, 1, 32'hCAFE0009, 0);
    checkCycle("lu_stall_wb", 3'd3, 3'd3, 1'b0);
    applyStimulus(9, 9, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    checkCycle("lu_done", 3'd0, 3'd0, 1'b0);

    applyStimulus(4, 0, 1, 0, 0, 0, 0, 0, 4, 1, 32'hDEADBEEF, 0);
    checkCycle("hold_cap", 3'd3, 3'd0, 1'b0);
    applyStimulus(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    checkCycle("hold_sel", 3'd4, 3'd0, 1'b0);
    checkOutput("hold_data", 64'(fwd_held_data[DATA_W-1:0]), 64'h0DEADBEEF);
    applyStimulus(4, 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    checkCycle("hold_clear_edge", 3'd4, 3'd0, 1'b0);
    applyStimulus(4, 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    checkCycle("hold_cleared", 3'd0, 3'd0, 1'b0);

    applyStimulus(0, 9, 1, 0, 9, 1, 1, 0, 0, 0, 32'h0, 1);
    checkCycle("dmem_no_bubble", 3'd0, 3'd0, 1'b0);
    applyStimulus(0, 9, 1, 0, 9, 1, 1, 0, 0, 0, 32'h0, 1);
    checkCycle("dmem_no_bubble2", 3'd0, 3'd0, 1'b0);
    applyStimulus(0, 9, 1, 0, 9, 1, 1, 0, 0, 0, 32'h0, 0);
    checkCycle("dmem_release", 3'd0, 3'd0, 1'b1);
    applyStimulus(0, 9, 1, 0, 9, 1, 1, 0, 0, 0, 32'h0, 1);
    checkCycle("lu_frozen", 3'd0, 3'd0, 1'b0);
    applyStimulus(0, 9, 1, 0, 9, 1, 1, 0, 0, 0, 32'h0, 0);
    checkCycle("lu_exit", 3'd0, 3'd0, 1'b0);
    applyStimulus(0, 9, 1, 0, 9, 1, 1, 0, 0, 0, 32'h0, 0);
    checkCycle("re_hazard", 3'd0, 3'd0, 1'b1);

    applyStimulus(4, 0, 1, 0, 0, 0, 0, 0, 4, 1, 32'h12345678, 0);
    checkCycle("cap_in_lu", 3'd3, 3'd0, 1'b0);
    applyStimulus(4, 9, 1, 0, 9, 1, 1, 0, 0, 0, 32'h0, 0);
    checkCycle("held_plus_hazard", 3'd4, 3'd0, 1'b1);
    applyStimulus(4, 9, 1, 0, 9, 1, 1, 0, 0, 0, 32'h0, 1);
    checkCycle("lu_before_reset", 3'd4, 3'd0, 1'b0);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_reset_sel", 64'(fwd_sel), 64'd0);
    checkOutput("async_reset_stall", 64'(stall_front), 64'd0);
    checkOutput("async_reset_held", 64'(fwd_held_data), 64'd0);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    dmem_stall = 1'b0;
    checkCycle("reset_rehazard", 3'd0, 3'd0, 1'b1);

    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    checkCycle("idle", 3'd0, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the EX-stage forwarding selector.
- Generalised to NUM_SRC operand ports and DATA_W-wide data.
- Adds load-use detection with a one-cycle stall/bubble FSM, and per-source hold registers that preserve a WB-forwarded value while EX is frozen.
- Sits beside the EX stage; drives the EX operand muxes and the pipeline stall/bubble controls.

Parameters:
NUM_SRC, 2, number of source operands checked (rs1, rs2, ...)
REG_W, 5, register-index width
DATA_W, 32, datapath width of WB data and hold registers

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset (0 = reset)
idex_rs  in  NUM_SRC*REG_W  source indices of the EX instruction; slot i = bits [i*REG_W +: REG_W]
idex_valid  in  1  EX holds a real instruction
ex_advance  in  1  EX/MEM register loads this cycle (EX instruction leaves EX)
exmem_rd  in  REG_W  MEM-stage destination
exmem_load_reg  in  1  MEM-stage instruction writes rd
exmem_is_load  in  1  MEM-stage instruction is a load
exmem_is_cmp  in  1  MEM-stage instruction is slt/slti/sltu/sltiu
memwb_rd  in  REG_W  WB-stage destination
memwb_load_reg  in  1  WB-stage instruction writes rd
wb_data  in  DATA_W  regfile write data in WB
dmem_stall  in  1  data-memory wait; whole pipeline frozen
fwd_sel  out  NUM_SRC*3  per-source fwd_sel_t
fwd_held_data  out  NUM_SRC*DATA_W  per-source hold-register contents
stall_front  out  1  freeze PC, IF/ID, ID/EX
bubble_ex  out  1  load a NOP into EX/MEM

Behaviour:
- fwd_sel_t encoding: FWD_RF=0, FWD_MEM_ALU=1, FWD_MEM_BR=2, FWD_WB=3, FWD_HELD=4.
- Per source i, let r = idex_rs[i]. Selection is combinational; first match wins:
  1. r==0, or !idex_valid -> FWD_RF.
  2. MEM match (exmem_load_reg && exmem_rd==r, rd != 0). exmem_is_load -> hazard flag, sel FWD_RF. Otherwise exmem_is_cmp ? FWD_MEM_BR : FWD_MEM_ALU.
  3. WB match (memwb_load_reg && memwb_rd==r, rd != 0) -> FWD_WB.
  4. held_valid[i] -> FWD_HELD.
  5. Else FWD_RF.
- lu_hazard = OR of the hazard flags over all sources.
- FSM states:
  - RUN: lu_hazard && !dmem_stall -> LU_STALL.
  - LU_STALL: !dmem_stall -> RUN; dmem_stall -> stay (frozen).
- In RUN with lu_hazard: stall_front=1, bubble_ex=1 combinationally, in the same cycle.
- In LU_STALL: stall_front=0, bubble_ex=0. The load is now in WB, so it forwards via FWD_WB.
- Exactly one bubble per load-use, regardless of how many sources match. The hazard in RUN is therefore a single-cycle stall.
- dmem_stall dominates:
  - stall_front=0, bubble_ex=0 (the global stall already freezes the pipeline).
  - FSM state and hold registers unchanged.
- Hold capture, per source:
  - Condition: !ex_advance && !dmem_stall && fwd_sel[i]==FWD_WB.
  - Action: hold[i] <= wb_data, held_valid[i] <= 1.
  - Purpose: keeps the value alive after the WB instruction retires.
- Hold clear: ex_advance clears all held_valid. Clear takes priority over capture in the same cycle.
- fwd_held_data is registered; it updates the cycle after capture.
- Reset (rst=0), asynchronous: state=RUN, held_valid=0, hold=0.
- While rst=0 the outputs are forced: stall_front=0, bubble_ex=0, fwd_sel=FWD_RF.
- Reset deassertion mid-hazard: the hazard is re-evaluated from RUN on the first cycle.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- Defined: adds outputs perf_lu_stalls[31:0] and perf_fwd_events[31:0].
  - perf_lu_stalls increments on each RUN->LU_STALL transition.
  - perf_fwd_events increments once per cycle when idex_valid && ex_advance && any fwd_sel != FWD_RF.
  - Both wrap at 2^32 and reset to 0.
- Undefined: neither port nor counters exist; all other behaviour is identical.

Decomposition:
- Add to datapath_mux_types: fwd_sel_t enum and fwd_state_t {RUN, LU_STALL}.
- Sub-module fwd_src_select, instantiated NUM_SRC times via generate:
  - combinational priority select plus hazard flag for one source;
  - hold register and held_valid for that source.
- Top level holds the FSM, hazard OR-reduction and optional counters.

Test Plan:
- MEM ALU forward: exmem_rd=5, exmem_load_reg=1, idex_rs={5,5} -> fwd_sel={1,1}; no stall.
- slt forward, rd=0 ignored:
  - exmem_is_cmp=1, rd=7, rs1=7 -> sel1=FWD_MEM_BR;
  - exmem_rd=0, rs=0 -> FWD_RF.
- Priority: exmem_rd=3 and memwb_rd=3, rs2=3 -> sel2=FWD_MEM_ALU; exmem_load_reg=0 -> FWD_WB.
- Load-use, both sources match: exmem_is_load=1, rd=9, rs={9,9} ->
  - stall_front=1, bubble_ex=1 for exactly 1 cycle;
  - next cycle FSM=LU_STALL, fwd_sel={3,3}.
- Hold: ex_advance=0, memwb_rd=4, rs1=4, wb_data=0xDEADBEEF ->
  - next cycle memwb_load_reg=0, sel1=FWD_HELD, fwd_held_data=0xDEADBEEF;
  - ex_advance=1 clears it.
- dmem_stall=1 during a load-use hazard -> no bubble, FSM holds. Asserting rst=0 mid-LU_STALL -> RUN, all held_valid=0 immediately.
